// File: rtl/mem_bus_arbiter_2_pkg.sv
// Shared definitions for the two-requester memory bus arbiter.
// State encodings and requester indices used by the arbiter and its bench.
package mem_bus_arbiter_2_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } arbState_e;

    localparam logic ReqFetch = 1'b0;
    localparam logic ReqLsu   = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_2_mux.sv
// Generic 2-input bus multiplexer; Sel = 0 picks MuxIn_0, Sel = 1 picks MuxIn_1.
module Mux_2 #(
    parameter int unsigned NrOfBits = 1
) (
    input  logic                Sel,
    input  logic [NrOfBits-1:0] MuxIn_0,
    input  logic [NrOfBits-1:0] MuxIn_1,
    output logic [NrOfBits-1:0] MuxOut
);

    assign MuxOut = Sel ? MuxIn_1 : MuxIn_0;

endmodule

// File: rtl/mem_bus_arbiter_2.sv
// Round-robin arbiter for the core's shared memory port (0 = fetch, 1 = load/store).
// Grant is held until MemAck or the watchdog aborts; results are returned for one cycle.
module mem_bus_arbiter_2
    import mem_bus_arbiter_2_pkg::*;
#(
    parameter int unsigned AddrBits      = 32,
    parameter int unsigned DataBits      = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                Req_0,
    input  logic [AddrBits-1:0] Addr_0,
    input  logic [DataBits-1:0] WData_0,
    input  logic                We_0,
    input  logic                Req_1,
    input  logic [AddrBits-1:0] Addr_1,
    input  logic [DataBits-1:0] WData_1,
    input  logic                We_1,
    output logic                Ack_0,
    output logic                Ack_1,
    output logic                Err,
    output logic [DataBits-1:0] RData,
    output logic                Grant,
    output logic                MemReq,
    output logic [AddrBits-1:0] MemAddr,
    output logic [DataBits-1:0] MemWData,
    output logic                MemWe,
    input  logic                MemAck,
    input  logic [DataBits-1:0] MemRData
);

    localparam int unsigned CountBits = $clog2(TimeoutCycles + 1);
    localparam logic [CountBits-1:0] WdLimit = CountBits'(TimeoutCycles);

    arbState_e              state;
    logic                   lastOwner;
    logic [CountBits-1:0]   wdCount;
    logic                   muxWe;

    Mux_2 #(.NrOfBits(AddrBits)) addrMux (
        .Sel     (Grant),
        .MuxIn_0 (Addr_0),
        .MuxIn_1 (Addr_1),
        .MuxOut  (MemAddr)
    );

    Mux_2 #(.NrOfBits(DataBits)) wdataMux (
        .Sel     (Grant),
        .MuxIn_0 (WData_0),
        .MuxIn_1 (WData_1),
        .MuxOut  (MemWData)
    );

    Mux_2 #(.NrOfBits(1)) weMux (
        .Sel     (Grant),
        .MuxIn_0 (We_0),
        .MuxIn_1 (We_1),
        .MuxOut  (muxWe)
    );

    assign MemWe = muxWe & MemReq;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            Grant     <= ReqFetch;
            lastOwner <= ReqLsu;
            MemReq    <= 1'b0;
            Ack_0     <= 1'b0;
            Ack_1     <= 1'b0;
            Err       <= 1'b0;
            RData     <= '0;
            wdCount   <= '0;
        end else begin
            Ack_0 <= 1'b0;
            Ack_1 <= 1'b0;
            Err   <= 1'b0;
            case (state)
                StBusy: begin
                    // An ack on the expiry cycle takes priority over the abort.
                    if (MemAck) begin
                        RData     <= MemRData;
                        Ack_0     <= (Grant == ReqFetch);
                        Ack_1     <= (Grant == ReqLsu);
                        lastOwner <= Grant;
                        MemReq    <= 1'b0;
                        wdCount   <= '0;
                        state     <= StResp;
                    end else if (wdCount == WdLimit) begin
                        RData     <= '0;
                        Err       <= 1'b1;
                        lastOwner <= Grant;
                        MemReq    <= 1'b0;
                        wdCount   <= '0;
                        state     <= StResp;
                    end else begin
                        wdCount <= wdCount + 1'b1;
                    end
                end
                StResp: begin
                    state <= StIdle;
                end
                default: begin
                    if (Req_0 || Req_1) begin
                        Grant  <= (Req_0 && Req_1) ? ~lastOwner : (Req_1 ? ReqLsu : ReqFetch);
                        MemReq <= 1'b1;
                        state  <= StBusy;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter_2.sv
// Directed and randomized transaction-level checks of mem_bus_arbiter_2.
module tb_mem_bus_arbiter_2;

    localparam int unsigned Timeout = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        Req_0, Req_1, We_0, We_1, MemAck;
    logic [31:0] Addr_0, Addr_1, WData_0, WData_1, MemRData;
    logic        Ack_0, Ack_1, Err, Grant, MemReq, MemWe;
    logic [31:0] RData, MemAddr, MemWData;

    int errors = 0;
    int checks = 0;

    // Transaction-level model state and per-transaction stimulus values.
    logic        modelLast;
    logic [31:0] a0, a1, d0, d1, rd;
    logic        w0, w1;

    mem_bus_arbiter_2 #(
        .AddrBits      (32),
        .DataBits      (32),
        .TimeoutCycles (Timeout)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .Req_0    (Req_0),
        .Addr_0   (Addr_0),
        .WData_0  (WData_0),
        .We_0     (We_0),
        .Req_1    (Req_1),
        .Addr_1   (Addr_1),
        .WData_1  (WData_1),
        .We_1     (We_1),
        .Ack_0    (Ack_0),
        .Ack_1    (Ack_1),
        .Err      (Err),
        .RData    (RData),
        .Grant    (Grant),
        .MemReq   (MemReq),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemWe    (MemWe),
        .MemAck   (MemAck),
        .MemRData (MemRData)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic randInputs();
        a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom; rd = $urandom;
        w0 = 1'($urandom_range(0, 1));
        w1 = 1'($urandom_range(0, 1));
    endtask

    // Runs one transaction starting from an IDLE cycle; ackCycle is the 1-based BUSY
    // cycle carrying MemAck (0 = never). Ends in the following IDLE cycle.
    task automatic doTxn(input logic r0, input logic r1, input int ackCycle, input bit dropReq);
        logic own;
        bit   acked;
        int   endCycle;
        Req_0 = r0; Addr_0 = a0; WData_0 = d0; We_0 = w0;
        Req_1 = r1; Addr_1 = a1; WData_1 = d1; We_1 = w1;
        own      = (r0 && r1) ? ~modelLast : r1;
        acked    = (ackCycle >= 1) && (ackCycle <= int'(Timeout) + 1);
        endCycle = acked ? ackCycle : int'(Timeout) + 1;
        tick();
        for (int k = 1; k <= endCycle; k++) begin
            check("busyMemReq", {31'd0, MemReq}, 32'd1);
            check("busyAck", {30'd0, Ack_1, Ack_0}, 32'd0);
            check("busyErr", {31'd0, Err}, 32'd0);
            if (k == 1) begin
                check("grant", {31'd0, Grant}, {31'd0, own});
                check("memAddr", MemAddr, own ? a1 : a0);
                check("memWData", MemWData, own ? d1 : d0);
                check("memWe", {31'd0, MemWe}, {31'd0, own ? w1 : w0});
                if (dropReq) begin
                    Req_0 = 1'b0;
                    Req_1 = 1'b0;
                end
            end
            MemAck   = (k == ackCycle);
            MemRData = (k == ackCycle) ? rd : $urandom;
            tick();
            MemAck = 1'b0;
        end
        check("respMemReq", {31'd0, MemReq}, 32'd0);
        check("respMemWe", {31'd0, MemWe}, 32'd0);
        check("respAck0", {31'd0, Ack_0}, {31'd0, acked && !own});
        check("respAck1", {31'd0, Ack_1}, {31'd0, acked && own});
        check("respErr", {31'd0, Err}, {31'd0, !acked});
        check("respRData", RData, acked ? rd : 32'd0);
        modelLast = own;
        Req_0 = 1'b0;
        Req_1 = 1'b0;
        tick();
        check("idleMemReq", {31'd0, MemReq}, 32'd0);
        check("idlePulse", {29'd0, Err, Ack_1, Ack_0}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        Req_0 = 0; Req_1 = 0; We_0 = 0; We_1 = 0; MemAck = 0;
        Addr_0 = 0; Addr_1 = 0; WData_0 = 0; WData_1 = 0; MemRData = 0;
        modelLast = 1'b1;
        tick();
        tick();
        check("rstMemReq", {31'd0, MemReq}, 32'd0);
        check("rstGrant", {31'd0, Grant}, 32'd0);
        check("rstPulses", {29'd0, Err, Ack_1, Ack_0}, 32'd0);
        check("rstRData", RData, 32'd0);
        reset = 1'b0;
        tick();

        // Single fetch read, MemAck two cycles after MemReq rises.
        randInputs();
        a0 = 32'h100; rd = 32'hDEADBEEF; w0 = 1'b0;
        doTxn(1'b1, 1'b0, 3, 1'b0);

        // Both requesting: strict alternation.
        for (int i = 0; i < 4; i++) begin
            randInputs();
            doTxn(1'b1, 1'b1, 2, 1'b0);
        end

        // LSU write.
        randInputs();
        a1 = 32'h200; d1 = 32'h12345678; w1 = 1'b1;
        doTxn(1'b0, 1'b1, 2, 1'b0);

        // Watchdog abort, then an LSU request is served.
        randInputs();
        doTxn(1'b1, 1'b0, 0, 1'b0);
        randInputs();
        doTxn(1'b0, 1'b1, 1, 1'b0);

        // MemAck on the expiry cycle wins over the abort.
        randInputs();
        doTxn(1'b1, 1'b0, int'(Timeout) + 1, 1'b0);

        // MemAck while idle is ignored.
        MemAck = 1'b1;
        MemRData = $urandom;
        tick();
        MemAck = 1'b0;
        check("strayAckMemReq", {31'd0, MemReq}, 32'd0);
        check("strayAckPulses", {29'd0, Err, Ack_1, Ack_0}, 32'd0);

        // Reset in BUSY coinciding with MemAck.
        Req_0 = 1'b1;
        Req_1 = 1'b1;
        tick();
        check("preRstMemReq", {31'd0, MemReq}, 32'd1);
        MemAck = 1'b1;
        reset  = 1'b1;
        tick();
        MemAck = 1'b0;
        reset  = 1'b0;
        Req_0  = 1'b0;
        Req_1  = 1'b0;
        modelLast = 1'b1;
        check("midRstMemReq", {31'd0, MemReq}, 32'd0);
        check("midRstGrant", {31'd0, Grant}, 32'd0);
        check("midRstPulses", {29'd0, Err, Ack_1, Ack_0}, 32'd0);
        tick();
        check("postRstPulses", {29'd0, Err, Ack_1, Ack_0}, 32'd0);

        // Randomized transactions, including some withdrawn requests and timeouts.
        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            randInputs();
            doTxn(sel[0], sel[1], int'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
